alu_operand_sequencer: RTL and testbench

ALU_OPERAND_SEQUENCER -- requirements
Module: alu_operand_sequencer

---
 rtl/alu_operand_sequencer_if.sv | 31 +++
 rtl/alu_operand_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_operand_sequencer_if.sv
// Bundles the switch/button inputs, the ALU handshake and the captured outputs of the sequencer.
// The environment uses the master modport and the sequencer uses the slave modport.
interface alu_operand_sequencer_if #(
    parameter int unsigned N = 4
);
    logic [N-1:0] sw;
    logic         btn_next_n;
    logic         btn_clr_n;
    logic [N-1:0] alu_result;
    logic         alu_carry_sum;
    logic         alu_carry_sub;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         op_sum;
    logic         op_subt;
    logic [N-1:0] res_q;
    logic         carry_q;
    logic         res_valid;
    logic [2:0]   state_o;

    modport master (
        output sw, btn_next_n, btn_clr_n, alu_result, alu_carry_sum, alu_carry_sub,
        input  a, b, op, op_sum, op_subt, res_q, carry_q, res_valid, state_o
    );

    modport slave (
        input  sw, btn_next_n, btn_clr_n, alu_result, alu_carry_sum, alu_carry_sub,
        output a, b, op, op_sum, op_subt, res_q, carry_q, res_valid, state_o
    );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Steps switch values into ALU operand, opcode and mode registers and captures the ALU result.
// Define ALU_SEQ_DEBOUNCE_EN to insert per-button debounce counters ahead of the edge detectors.
module alu_operand_sequencer #(
    parameter int unsigned N               = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input logic                   clk,
    input logic                   rst_n,
    alu_operand_sequencer_if.slave bus
);

    if (N < 3 || DEBOUNCE_CYCLES < 1) begin : gen_param_check
        $error("alu_operand_sequencer: N must be >= 3 and DEBOUNCE_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        StLoadA    = 3'd0,
        StLoadB    = 3'd1,
        StLoadOp   = 3'd2,
        StLoadMode = 3'd3,
        StExec     = 3'd4,
        StShow     = 3'd5
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic [2:0]   op_q, op_d;
    logic         op_sum_q, op_sum_d;
    logic         op_subt_q, op_subt_d;
    logic [N-1:0] res_q, res_d;
    logic         carry_q, carry_d;

    // Bit 0 carries the next button, bit 1 the clear button.
    logic [1:0] btn_raw;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] level;
    logic [1:0] prev_q;
    logic [1:0] press;
    logic       next_pulse;
    logic       clr_pulse;

    assign btn_raw = {bus.btn_clr_n, bus.btn_next_n};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
            prev_q  <= 2'b11;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            prev_q  <= level;
        end
    end

`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0][CntW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]           level_q, level_d;

    // The counter tracks consecutive cycles the synchronized input disagrees with the level.
    always_comb begin
        level_d  = level_q;
        db_cnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            level_q  <= 2'b11;
        end else begin
            db_cnt_q <= db_cnt_d;
            level_q  <= level_d;
        end
    end

    assign level = level_q;
`else
    assign level = sync2_q;
`endif

    assign press      = prev_q & ~level;
    assign next_pulse = press[0];
    assign clr_pulse  = press[1];

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        op_sum_d  = op_sum_q;
        op_subt_d = op_subt_q;
        res_d     = res_q;
        carry_d   = carry_q;

        if (clr_pulse) begin
            state_d   = StLoadA;
            a_d       = '0;
            b_d       = '0;
            op_d      = '0;
            op_sum_d  = 1'b0;
            op_subt_d = 1'b0;
            res_d     = '0;
            carry_d   = 1'b0;
        end else begin
            case (state_q)
                StLoadA: begin
                    if (next_pulse) begin
                        a_d     = bus.sw;
                        state_d = StLoadB;
                    end
                end
                StLoadB: begin
                    if (next_pulse) begin
                        b_d     = bus.sw;
                        state_d = StLoadOp;
                    end
                end
                StLoadOp: begin
                    if (next_pulse) begin
                        op_d    = bus.sw[2:0];
                        state_d = StLoadMode;
                    end
                end
                StLoadMode: begin
                    if (next_pulse) begin
                        {op_subt_d, op_sum_d} = bus.sw[1:0];
                        state_d               = StExec;
                    end
                end
                StExec: begin
                    // Subtract mode takes precedence when both mode bits are set.
                    res_d   = bus.alu_result;
                    carry_d = op_subt_q ? bus.alu_carry_sub : (op_sum_q & bus.alu_carry_sum);
                    state_d = StShow;
                end
                StShow: begin
                    if (next_pulse) begin
                        state_d = StLoadA;
                    end
                end
                default: state_d = StLoadA;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StLoadA;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            op_sum_q  <= 1'b0;
            op_subt_q <= 1'b0;
            res_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            op_sum_q  <= op_sum_d;
            op_subt_q <= op_subt_d;
            res_q     <= res_d;
            carry_q   <= carry_d;
        end
    end

    assign bus.a         = a_q;
    assign bus.b         = b_q;
    assign bus.op        = op_q;
    assign bus.op_sum    = op_sum_q;
    assign bus.op_subt   = op_subt_q;
    assign bus.res_q     = res_q;
    assign bus.carry_q   = carry_q;
    assign bus.res_valid = (state_q == StShow);
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed and randomized checks of alu_operand_sequencer against a field-capture reference model.
// Expected press latency follows ALU_SEQ_DEBOUNCE_EN the same way the design build does.
module tb_alu_operand_sequencer;

    localparam int unsigned N = 4;
    localparam int unsigned D = 16;
`ifdef ALU_SEQ_DEBOUNCE_EN
    localparam int Lat = D + 3;
`else
    localparam int Lat = 3;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    alu_operand_sequencer_if #(.N(N)) bus ();

    alu_operand_sequencer #(
        .N               (N),
        .DEBOUNCE_CYCLES (D)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream ALU: returns {carry, result} for the selected mode.
    function automatic logic [N:0] alu_fn(input logic [N-1:0] x, input logic [N-1:0] y,
                                          input logic [2:0] o, input logic s, input logic d);
        int sum_i;
        sum_i = int'(x) + int'(y);
        if (d) return {x >= y, N'(int'(x) - int'(y))};
        if (s) return (N + 1)'(sum_i);
        case (o)
            3'd0:    return {1'b0, x & y};
            3'd1:    return {1'b0, x | y};
            3'd2:    return {1'b0, x ^ y};
            3'd3:    return {1'b0, ~x};
            3'd4:    return {1'b0, N'(sum_i)};
            3'd5:    return {1'b0, N'(int'(x) - int'(y))};
            3'd6:    return {1'b0, x << 1};
            default: return {1'b0, y};
        endcase
    endfunction

    logic [N:0] alu_full;
    assign alu_full          = alu_fn(bus.a, bus.b, bus.op, 1'b0, 1'b0);
    assign bus.alu_result    = alu_fn(bus.a, bus.b, bus.op, bus.op_sum, bus.op_subt)
                               >> 0 & {1'b0, {N{1'b1}}};
    assign bus.alu_carry_sum = ((int'(bus.a) + int'(bus.b)) >= (1 << N));
    assign bus.alu_carry_sub = (bus.a >= bus.b);

    // Reference model: which field the next capture fills, and the captured values.
    int           m_fields;  // 0..3 fields captured, 4 = result on show
    logic [N-1:0] m_a, m_b, m_res;
    logic [2:0]   m_op;
    logic         m_sum, m_subt, m_carry;

    task automatic model_clear();
        m_fields = 0;
        m_a = '0; m_b = '0; m_op = '0; m_sum = 1'b0; m_subt = 1'b0; m_res = '0; m_carry = 1'b0;
    endtask

    task automatic model_apply(input bit nxt, input bit clr, input logic [N-1:0] swv);
        logic [N:0] r;
        if (clr) begin
            model_clear();
        end else if (nxt) begin
            if (m_fields == 0) m_a = swv;
            else if (m_fields == 1) m_b = swv;
            else if (m_fields == 2) m_op = swv[2:0];
            else if (m_fields == 3) begin
                m_subt = swv[1];
                m_sum  = swv[0];
                r      = alu_fn(m_a, m_b, m_op, m_sum, m_subt);
                m_res  = r[N-1:0];
                if (m_subt) m_carry = (m_a >= m_b);
                else if (m_sum) m_carry = ((int'(m_a) + int'(m_b)) >= (1 << N));
                else m_carry = 1'b0;
            end
            m_fields = (m_fields == 4) ? 0 : m_fields + 1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        // After a full sequence the state sits in show (code 5), having passed through exec.
        check({tag, "_state"}, 32'(bus.state_o), (m_fields == 4) ? 32'd5 : 32'(m_fields));
        check({tag, "_a"}, 32'(bus.a), 32'(m_a));
        check({tag, "_b"}, 32'(bus.b), 32'(m_b));
        check({tag, "_op"}, 32'(bus.op), 32'(m_op));
        check({tag, "_op_sum"}, 32'(bus.op_sum), 32'(m_sum));
        check({tag, "_op_subt"}, 32'(bus.op_subt), 32'(m_subt));
        check({tag, "_res_q"}, 32'(bus.res_q), 32'(m_res));
        check({tag, "_carry_q"}, 32'(bus.carry_q), 32'(m_carry));
        check({tag, "_res_valid"}, 32'(bus.res_valid), 32'(m_fields == 4));
    endtask

    // Press and release the chosen buttons, then update the model and compare everything.
    task automatic press(input bit nxt, input bit clr, input logic [N-1:0] swv,
                         input int hold, input string tag);
        bus.sw = swv;
        @(posedge clk);
        #1;
        if (nxt) bus.btn_next_n = 1'b0;
        if (clr) bus.btn_clr_n = 1'b0;
        repeat (hold) @(posedge clk);
        #1;
        bus.btn_next_n = 1'b1;
        bus.btn_clr_n  = 1'b1;
        repeat (Lat + 3) @(posedge clk);
        #1;
        model_apply(nxt, clr, swv);
        check_all(tag);
    endtask

    initial begin
        int edges;
        checks          = 0;
        failures        = 0;
        rst_n           = 1'b0;
        bus.sw          = '0;
        bus.btn_next_n  = 1'b1;
        bus.btn_clr_n   = 1'b1;
        model_clear();

        // Reset values while reset is held, then 50 idle cycles with buttons released.
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check_all("idle50");

        // Capture lands on the expected edge after a clean falling input.
        bus.sw = 4'b1010;
        @(posedge clk);
        #1;
        bus.btn_next_n = 1'b0;
        edges = 0;
        while (bus.state_o == 3'd0 && edges < Lat + 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("press_latency", 32'(edges), 32'(Lat));
        repeat (Lat + 3) @(posedge clk);
        #1;
        check("held_single_advance", 32'(bus.state_o), 32'd1);
        bus.btn_next_n = 1'b1;
        repeat (Lat + 3) @(posedge clk);
        #1;
        model_apply(1'b1, 1'b0, 4'b1010);
        check_all("first_capture");
        press(1'b0, 1'b1, 4'b0000, Lat + 2, "clear_from_b");

        // Directed sequence: 1111 + 1000 in add mode gives 0111 with carry.
        press(1'b1, 1'b0, 4'b1111, Lat + 2, "dir_a");
        press(1'b1, 1'b0, 4'b1000, Lat + 2, "dir_b");
        press(1'b1, 1'b0, 4'b0111, Lat + 2, "dir_op");
        press(1'b1, 1'b0, 4'b0001, Lat + 2, "dir_mode");
        check("dir_res_literal", 32'(bus.res_q), 32'h7);
        check("dir_carry_literal", 32'(bus.carry_q), 32'h1);
        press(1'b1, 1'b0, 4'b0000, Lat + 2, "show_to_load_a");

        // Clear and next together in LOAD_OP: clear wins.
        press(1'b1, 1'b0, 4'b0101, Lat + 2, "cn_a");
        press(1'b1, 1'b0, 4'b0011, Lat + 2, "cn_b");
        press(1'b1, 1'b1, 4'b0110, Lat + 2, "clr_and_next");

`ifdef ALU_SEQ_DEBOUNCE_EN
        // A 10-cycle glitch is filtered; a 40-cycle hold advances once.
        @(posedge clk);
        #1;
        bus.btn_next_n = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        bus.btn_next_n = 1'b1;
        repeat (Lat + 5) @(posedge clk);
        #1;
        check_all("glitch_filtered");
        press(1'b1, 1'b0, 4'b1100, 40, "hold40");
        press(1'b0, 1'b1, 4'b0000, Lat + 2, "hold40_clear");
`endif

        // Reset pulsed while the sequencer sits in EXEC.
        press(1'b1, 1'b0, 4'b1110, Lat + 2, "rx_a");
        press(1'b1, 1'b0, 4'b0011, Lat + 2, "rx_b");
        press(1'b1, 1'b0, 4'b0100, Lat + 2, "rx_op");
        bus.sw = 4'b0010;
        @(posedge clk);
        #1;
        bus.btn_next_n = 1'b0;
        edges = 0;
        while (bus.state_o != 3'd4 && edges < Lat + 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("exec_reached", 32'(bus.state_o), 32'd4);
        rst_n = 1'b0;
        #1;
        bus.btn_next_n = 1'b1;
        check("rst_exec_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_exec_res_q", 32'(bus.res_q), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (Lat + 5) @(posedge clk);
        #1;
        model_clear();
        check_all("after_exec_reset");
        press(1'b1, 1'b0, 4'b1001, Lat + 2, "post_a");
        press(1'b1, 1'b0, 4'b0110, Lat + 2, "post_b");
        press(1'b1, 1'b0, 4'b0101, Lat + 2, "post_op");
        press(1'b1, 1'b0, 4'b0010, Lat + 2, "post_mode");

        // Randomized presses with occasional clears and simultaneous presses.
        for (int i = 0; i < 30; i++) begin
            int r;
            r = $urandom_range(0, 9);
            press(r != 0, r <= 1, N'($urandom), Lat + 2, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
